case_9_sdiv_26s_12s_14_seq: RTL and testbench
=============================================

Name: case_9_sdiv_26s_12s_14_seq

Overview:
- Multi-cycle signed integer divider. It is the inverse of the case_9 signed multiplier core and produces a quotient and remainder from a signed dividend and a signed divisor.
- Used by the case_9 datapath for division and modulo operations.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- start/done handshake with a clock-enable stall, matching the HLS core interface.

Parameters:
ID, 1, instance identifier; no functional effect
din0_WIDTH, 26, signed dividend width (also the iteration count)
din1_WIDTH, 12, signed divisor width; remainder width
dout_WIDTH, 14, quotient output width (low bits of the full quotient)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; when low, all registers hold
start  in  1  request; sampled only when ce=1 and busy=0
din0  in  din0_WIDTH  signed dividend, captured on accepted start
din1  in  din1_WIDTH  signed divisor, captured on accepted start
busy  out  1  high in CALC and SIGN states
done  out  1  one-cycle result-valid pulse
dout  out  dout_WIDTH  signed quotient
rem  out  din1_WIDTH  signed remainder
div_by_zero  out  1  high with done when the divisor was 0; held with results

Behaviour:
- Reset (sync, when reset=1, regardless of ce):
  - state=IDLE, counter=0.
  - busy=0, done=0, dout=0, rem=0, div_by_zero=0.
  - Reset mid-operation aborts the operation; no done is produced.
- State machine: IDLE -> CALC -> SIGN -> DONE -> IDLE.
- All transitions and register updates occur only on edges where ce=1.
- IDLE:
  - start=1 captures the operands.
  - Captures |din0| and |din1| as unsigned magnitudes, plus both sign bits.
  - Clears the partial remainder and sets counter=din0_WIDTH-1.
  - Goes to CALC.
- CALC, one iteration per enabled edge:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - If partial remainder >= |divisor|, subtract and set the quotient bit to 1; otherwise set it to 0.
  - Decrement the counter. Leave CALC after din0_WIDTH iterations.
- SIGN:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Truncation is toward zero (C semantics); the remainder sign follows the dividend.
  - Register dout (low dout_WIDTH bits of the quotient) and rem.
  - Go to DONE.
- DONE:
  - done=1 for exactly one enabled cycle.
  - start is accepted here as in IDLE, giving back-to-back operation.
- Latency: with start sampled at edge E0 and ce continuously high, done is high in the cycle following edge E0+din0_WIDTH+1. That is 28 cycles at default parameters. Each ce=0 cycle adds one cycle.
- Result retention: dout, rem and div_by_zero hold their values until the next done or reset.
- start is ignored while busy=1, and the operands are not recaptured.
- Divide by zero (din1=0):
  - Runs the full latency.
  - dout = all ones; rem = low din1_WIDTH bits of din0; div_by_zero=1.
- Overflow: the full quotient is computed at din0_WIDTH+1 bits and then truncated to dout_WIDTH bits. For example, -2^25 / -1 gives dout=0. No flag is raised.
- ce low during DONE: done stays high until the next enabled edge.

Test Plan:
- din0=1000, din1=7, start for one cycle at E0 -> done high exactly at E0+28 for one cycle; dout=142, rem=6, div_by_zero=0.
- Sign cases:
  - -1000/7 -> dout=-142 (0x3F72), rem=-6 (0xFFA).
  - 1000/-7 -> dout=-142, rem=6.
  - -1000/-7 -> dout=142, rem=-6.
- din0=123, din1=0 -> after 28 cycles: dout=0x3FFF, rem=123, div_by_zero=1. The next division 10/3 gives dout=3, rem=1 and clears div_by_zero.
- Back-to-back: a new start (50/5) in the DONE cycle of 1000/7 -> second done 28 cycles later with dout=10, rem=0. A start pulse at cycle 10 of the busy window is ignored and the results are unchanged.
- ce held low for 5 cycles mid-CALC -> done at E0+33 with correct results; done remains high while ce is low in DONE.
- reset asserted at cycle 15 of CALC -> next cycle busy=0, done=0, dout=0, rem=0; no done appears. Overflow check: din0=1048576, din1=1 -> dout=0, rem=0.

Source files
------------

// File: rtl/case_9_sdiv_26s_12s_14_seq.sv
// case_9_sdiv_26s_12s_14_seq: multi-cycle signed restoring divider, one quotient bit per enabled clock
module case_9_sdiv_26s_12s_14_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(din0_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [din1_WIDTH:0] r_q, t, r_d;
  logic [din0_WIDTH-1:0] dv_q;
  logic [din1_WIDTH-1:0] dm_q, rm;
  logic s0_q, s1_q, ge, accept;
  logic [din0_WIDTH:0] q_full, q_sgn;
  logic [dout_WIDTH-1:0] dout_q;
  logic [din1_WIDTH-1:0] rem_q;
  logic dz_q, dz;
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (ce)
      unique case (state_q)
        IDLE, DONE: state_d = start ? CALC : IDLE;
        CALC: state_d = (cnt_q == '0) ? SIGN : CALC;
        SIGN: state_d = DONE;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    busy = (state_q == CALC) || (state_q == SIGN);
    done = (state_q == DONE);
  end
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  // dv_q shifts dividend bits out of its MSB while quotient bits enter at the LSB
  assign t = {r_q[din1_WIDTH-1:0], dv_q[din0_WIDTH-1]};
  assign ge = t >= {1'b0, dm_q};
  assign r_d = ge ? t - {1'b0, dm_q} : t;
  // With a zero divisor every step subtracts nothing, so r_q ends holding the low dividend bits
  assign dz = (dm_q == '0);
  assign q_full = {1'b0, dv_q};
  assign q_sgn = (s0_q ^ s1_q) ? -q_full : q_full;
  assign rm = r_q[din1_WIDTH-1:0];
  always_ff @(posedge clk)
    if (reset) begin
      {cnt_q, r_q, dv_q, dm_q, s0_q, s1_q} <= '0;
      {dout_q, rem_q, dz_q} <= '0;
    end else if (ce) begin
      if (accept) begin
        dv_q <= din0[din0_WIDTH-1] ? -din0 : din0;
        dm_q <= din1[din1_WIDTH-1] ? -din1 : din1;
        s0_q <= din0[din0_WIDTH-1];
        s1_q <= din1[din1_WIDTH-1];
        r_q <= '0;
        cnt_q <= CW'(din0_WIDTH - 1);
      end else if (state_q == CALC) begin
        r_q <= r_d;
        dv_q <= {dv_q[din0_WIDTH-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == SIGN) begin
        dout_q <= dz ? '1 : q_sgn[dout_WIDTH-1:0];
        rem_q <= s0_q ? -rm : rm;
        dz_q <= dz;
      end
    end
  assign dout = dout_q;
  assign rem = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_case_9_sdiv_26s_12s_14_seq.sv
// tb_case_9_sdiv_26s_12s_14_seq: directed and random checks of the signed divider against C-style division
module tb_case_9_sdiv_26s_12s_14_seq;
  logic clk = 0, reset = 0, ce = 1, start = 0;
  logic [25:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic busy, done, div_by_zero;
  logic [13:0] dout;
  logic [11:0] rem;
  int n_chk = 0, n_fail = 0;
  int lat;
  case_9_sdiv_26s_12s_14_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .busy(busy), .done(done), .dout(dout), .rem(rem), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic signed [25:0] a, input logic signed [11:0] b);
    din0 = a;
    din1 = b;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input int stall_at, input int stall_len, input int ign_at, output int l);
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      tick();
      l++;
      if (l == 1) chk("busy_after_start", busy, 1);
      if (l == stall_at) ce = 0;
      if (l == stall_at + stall_len) ce = 1;
      if (l == ign_at) begin
        din0 = 26'd777;
        din1 = 12'd3;
        start = 1;
      end else start = 0;
    end
    ce = 1;
    start = 0;
  endtask
  task automatic check_res(input string tag, input logic signed [25:0] a, input logic signed [11:0] b);
    longint sa, sb, q, r;
    logic [13:0] eq;
    logic [11:0] er;
    logic ez;
    sa = a;
    sb = b;
    if (sb == 0) begin
      eq = 14'h3fff;
      er = a[11:0];
      ez = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eq = q[13:0];
      er = r[11:0];
      ez = 0;
    end
    chk({tag, "_dout"}, dout, eq);
    chk({tag, "_rem"}, rem, er);
    chk({tag, "_dz"}, div_by_zero, ez);
  endtask
  task automatic run(input string tag, input logic signed [25:0] a, input logic signed [11:0] b);
    start_op(a, b);
    wait_done(-1, 0, -1, lat);
    chk({tag, "_lat"}, lat, 27);
    check_res(tag, a, b);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask
  initial begin
    logic [31:0] ra, rb;
    int sa, sl, saw;
    ce = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    ce = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dz", div_by_zero, 0);
    run("p_p", 26'sd1000, 12'sd7);
    run("n_p", -26'sd1000, 12'sd7);
    run("p_n", 26'sd1000, -12'sd7);
    run("n_n", -26'sd1000, -12'sd7);
    run("dz", 26'sd123, 12'sd0);
    run("after_dz", 26'sd10, 12'sd3);
    run("ovf_min", 26'h2000000, -12'sd1);
    run("ovf_big", 26'sd1048576, 12'sd1);
    run("min_div", -26'sd5000, 12'h800);
    // ignored start mid-busy, then back-to-back start in the DONE cycle
    start_op(26'sd1000, 12'sd7);
    wait_done(-1, 0, 10, lat);
    chk("ign_lat", lat, 27);
    check_res("ign", 26'sd1000, 12'sd7);
    start_op(26'sd50, 12'sd5);
    chk("b2b_busy", busy, 1);
    wait_done(-1, 0, -1, lat);
    chk("b2b_lat", lat, 27);
    check_res("b2b", 26'sd50, 12'sd5);
    tick();
    // ce stall mid-CALC, then ce low while done is up
    start_op(-26'sd99999, 12'sd13);
    wait_done(10, 5, -1, lat);
    chk("stall_lat", lat, 32);
    check_res("stall", -26'sd99999, 12'sd13);
    ce = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_held", done, 1);
    end
    ce = 1;
    tick();
    chk("done_release", done, 0);
    // reset mid-operation
    start_op(26'sd1000, 12'sd7);
    for (int i = 0; i < 15; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, 0);
    chk("abort_rem", rem, 0);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) saw++;
    end
    chk("abort_no_done", saw, 0);
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      sa = $urandom_range(2, 20);
      sl = $urandom_range(0, 3);
      start_op(ra[25:0], rb[11:0]);
      wait_done(sa, sl, -1, lat);
      chk("rnd_lat", lat, 27 + sl);
      check_res("rnd", ra[25:0], rb[11:0]);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
